// File: rtl/alu_operand_stage_pkg.sv
// Shared types and source-priority decode for the ALU operand staging path.
package alu_operand_stage_pkg;

  typedef enum logic [1:0] {
    A_HOLD   = 2'd0,
    A_SYSBUS = 2'd1,
    A_ZERO   = 2'd2
  } a_src_t;

  typedef enum logic [1:0] {
    B_HOLD    = 2'd0,
    B_DATA    = 2'd1,
    B_INVDATA = 2'd2,
    B_ADL     = 2'd3
  } b_src_t;

  function automatic a_src_t a_select(input logic sys_en, input logic zero_en);
    a_src_t src;
    if (sys_en) begin
      src = A_SYSBUS;
    end else if (zero_en) begin
      src = A_ZERO;
    end else begin
      src = A_HOLD;
    end
    return src;
  endfunction

  function automatic b_src_t b_select(input logic data_en, input logic inv_en,
                                      input logic adl_en);
    b_src_t src;
    if (data_en) begin
      src = B_DATA;
    end else if (inv_en) begin
      src = B_INVDATA;
    end else if (adl_en) begin
      src = B_ADL;
    end else begin
      src = B_HOLD;
    end
    return src;
  endfunction

endpackage

// File: rtl/alu_operand_stage_fifo.sv
// Operand-set queue: storage, wrapping pointers, occupancy and sticky error flags.
module alu_operand_stage_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [2*WIDTH:0]   push_data,
  output logic [2*WIDTH:0]   head_data,
  output logic               valid,
  output logic               full,
  output logic               overflow_err,
  output logic               underflow_err
);

  localparam int SW = 2 * WIDTH + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [SW-1:0] mem_r [DEPTH];
  logic [PW-1:0] head_r, tail_r, head_inc_s, tail_inc_s;
  logic [CW-1:0] count_r, count_nxt_s;
  logic          valid_r, full_r, overflow_r, underflow_r;
  logic          do_push_s, do_pop_s;

  // Next-state decode; a full queue still accepts a push when the head leaves.
  always_comb begin
    do_pop_s   = pop && valid_r;
    do_push_s  = push && (!full_r || do_pop_s);
    head_inc_s = (head_r == PW'(DEPTH - 1)) ? {PW{1'b0}} : head_r + PW'(1);
    tail_inc_s = (tail_r == PW'(DEPTH - 1)) ? {PW{1'b0}} : tail_r + PW'(1);
    if (do_push_s && !do_pop_s) begin
      count_nxt_s = count_r + CW'(1);
    end else if (do_pop_s && !do_push_s) begin
      count_nxt_s = count_r - CW'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Queue state registers with sticky error capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {SW{1'b0}};
      end
      head_r      <= {PW{1'b0}};
      tail_r      <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
      valid_r     <= 1'b0;
      full_r      <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (do_push_s) begin
        mem_r[tail_r] <= push_data;
        tail_r        <= tail_inc_s;
      end
      if (do_pop_s) begin
        head_r <= head_inc_s;
      end
      count_r <= count_nxt_s;
      valid_r <= (count_nxt_s != {CW{1'b0}});
      full_r  <= (count_nxt_s == CW'(DEPTH));
      if (push && full_r && !pop) begin
        overflow_r <= 1'b1;
      end
      if (pop && !valid_r) begin
        underflow_r <= 1'b1;
      end
    end
  end

  // Head entry is presented only while the queue holds data.
  always_comb begin
    if (valid_r) begin
      head_data = mem_r[head_r];
    end else begin
      head_data = {SW{1'b0}};
    end
  end

  assign valid         = valid_r;
  assign full          = full_r;
  assign overflow_err  = overflow_r;
  assign underflow_err = underflow_r;

endmodule

// File: rtl/alu_operand_stage.sv
// ALU operand staging: source-priority decode, A/B/carry stage registers, commit queue.
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk_IN,
  input  logic             rst_IN,
  input  logic [WIDTH-1:0] systemBus_IN,
  input  logic [WIDTH-1:0] dataBus_IN,
  input  logic [WIDTH-1:0] addressLow_IN,
  input  logic             aSystemBus_EN,
  input  logic             aZero_EN,
  input  logic             bDataBus_EN,
  input  logic             bInvDataBus_EN,
  input  logic             bAddressLow_EN,
  input  logic             carry_IN,
  input  logic             carry_EN,
  input  logic             commit_EN,
  input  logic             pop_EN,
  output logic [WIDTH-1:0] a_REG_OUT,
  output logic [WIDTH-1:0] b_REG_OUT,
  output logic             carry_REG_OUT,
  output logic             valid_OUT,
  output logic             full_OUT,
  output logic             overflow_ERR_OUT,
  output logic             underflow_ERR_OUT
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry;
  } operand_set_t;

  a_src_t           a_src_s;
  b_src_t           b_src_s;
  logic [WIDTH-1:0] a_stage_r, b_stage_r, a_nxt_s, b_nxt_s;
  logic             c_stage_r, c_nxt_s;
  operand_set_t     push_set_s, head_set_s;

  // Next stage values; commit pushes these so same-cycle loads bypass into the queue.
  always_comb begin
    a_src_s = a_select(aSystemBus_EN, aZero_EN);
    b_src_s = b_select(bDataBus_EN, bInvDataBus_EN, bAddressLow_EN);
    case (a_src_s)
      A_SYSBUS: a_nxt_s = systemBus_IN;
      A_ZERO:   a_nxt_s = {WIDTH{1'b0}};
      default:  a_nxt_s = a_stage_r;
    endcase
    case (b_src_s)
      B_DATA:    b_nxt_s = dataBus_IN;
      B_INVDATA: b_nxt_s = ~dataBus_IN;
      B_ADL:     b_nxt_s = addressLow_IN;
      default:   b_nxt_s = b_stage_r;
    endcase
    if (carry_EN) begin
      c_nxt_s = carry_IN;
    end else begin
      c_nxt_s = c_stage_r;
    end
    push_set_s = '{a: a_nxt_s, b: b_nxt_s, carry: c_nxt_s};
  end

  // Staging registers.
  always_ff @(posedge clk_IN) begin
    if (rst_IN) begin
      a_stage_r <= {WIDTH{1'b0}};
      b_stage_r <= {WIDTH{1'b0}};
      c_stage_r <= 1'b0;
    end else begin
      a_stage_r <= a_nxt_s;
      b_stage_r <= b_nxt_s;
      c_stage_r <= c_nxt_s;
    end
  end

  alu_operand_stage_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk           (clk_IN),
    .rst           (rst_IN),
    .push          (commit_EN),
    .pop           (pop_EN),
    .push_data     (push_set_s),
    .head_data     (head_set_s),
    .valid         (valid_OUT),
    .full          (full_OUT),
    .overflow_err  (overflow_ERR_OUT),
    .underflow_err (underflow_ERR_OUT)
  );

  assign a_REG_OUT     = head_set_s.a;
  assign b_REG_OUT     = head_set_s.b;
  assign carry_REG_OUT = head_set_s.carry;

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Clocked, parametrised successor to the ALU A-side input register. It stages both ALU operands (A, B) plus carry-in from the internal buses and queues committed operand sets in a small FIFO. The ALU can then consume one set per cycle while the decoder stages the next. It sits between the bus fabric (system bus, data bus, address-low bus) and the ALU adder.

## Interface
Parameters:
- WIDTH, 8, operand width in bits.
- DEPTH, 2, operand-set queue entries; legal 1..8.

Ports:
- clk_IN  input  1  clock; every register updates on its rising edge.
- rst_IN  input  1  reset, synchronous and active-high.
- systemBus_IN  input  WIDTH  A-side source.
- dataBus_IN  input  WIDTH  B-side source, true or inverted.
- addressLow_IN  input  WIDTH  B-side source.
- aSystemBus_EN / aZero_EN  input  1  A-stage load from system bus / load zero.
- bDataBus_EN / bInvDataBus_EN / bAddressLow_EN  input  1  B-stage load selects.
- carry_IN  input  1  carry-in value; carry_EN  input  1  carry-stage load.
- commit_EN  input  1  push the staged set into the queue.
- pop_EN  input  1  ALU has consumed the head set.
- a_REG_OUT / b_REG_OUT  output  WIDTH  head-of-queue operands.
- carry_REG_OUT  output  1  head-of-queue carry-in.
- valid_OUT  output  1  queue non-empty.
- full_OUT  output  1  queue holds DEPTH sets.
- overflow_ERR_OUT / underflow_ERR_OUT  output  1  sticky error flags.

## Operation
- Staging registers aStage, bStage, cStage hold their value when no enable is active. There is no latch behaviour.
- A priority: aSystemBus_EN > aZero_EN.
- B priority: bDataBus_EN > bInvDataBus_EN (loads ~dataBus_IN) > bAddressLow_EN.
- Commit bypass: commit_EN pushes the *next* staged values. Loads and commit in the same cycle push the newly loaded data. Unloaded fields push their held stage value.
- Push when not full: the set is written at the tail and count increments.
- Push when full without pop: the set is dropped, count is unchanged, and overflow_ERR_OUT sets.
- Pop when non-empty: the head advances and count decrements.
- Pop when empty: ignored; underflow_ERR_OUT sets.
- Simultaneous push and pop:
  - When full: both take effect, count is unchanged, and no error is raised.
  - When empty: the push takes effect and the pop is an underflow.
- Head/tail pointers wrap modulo DEPTH. count is $clog2(DEPTH+1) bits wide.
- Outputs are the head entry. When valid_OUT=0 the operand outputs are 0.
- Error flags clear only on rst_IN.

## Timing
- Reset: stages, queue, pointers, count = 0. All outputs = 0.
- rst_IN has priority over every enable in the same cycle, including mid-operation. Queued sets are discarded.
- Latency: a commit at edge N into an empty queue gives valid_OUT=1 with the operands after edge N (one cycle).
- Throughput: one push and one pop per cycle. With DEPTH≥1 and simultaneous push/pop, there are no bubbles.
- full_OUT, valid_OUT and the error flags are registered and updated on the same edge as count.
- No combinational path from pop_EN or commit_EN to any output.

## Structure
- Package ALU_OPERAND_PKG holds:
  - enum aSrc_t {A_HOLD, A_SYSBUS, A_ZERO};
  - enum bSrc_t {B_HOLD, B_DATA, B_INVDATA, B_ADL};
  - parameterised struct operandSet_t {a, b, carry}.
- Sub-module OPERAND_FIFO (WIDTH, DEPTH) contains storage, pointers, count, full/valid and error flags.
- Top level holds the source-priority decode and the staging registers.

## Test plan
- Reset: assert rst_IN 2 cycles with enables active → all outputs 0, valid_OUT=0, error flags 0.
- Priority/inversion: dataBus_IN=0x5A with bDataBus_EN+bInvDataBus_EN, then commit → b_REG_OUT=0x5A.
  - Next set with only bInvDataBus_EN → 0xA5 at head after pop.
- Bypass: cycle N systemBus_IN=0x33, aSystemBus_EN=1, commit_EN=1 → after edge N a_REG_OUT=0x33, valid_OUT=1.
- Full/overflow (DEPTH=2): commit 0x01, 0x02, 0x03 without pop → full_OUT=1, 0x03 dropped, overflow_ERR_OUT=1.
  - Pops then yield 0x01, 0x02, then valid_OUT=0.
- Full push+pop: full queue {0x10, 0x11}, commit 0x12 with pop_EN → head 0x11, count 2, no error.
  - Repeat 10 cycles to exercise pointer wrap.
- Underflow/reset mid-flight: pop_EN on empty → underflow_ERR_OUT=1.
  - Then 1 set queued plus rst_IN → valid_OUT=0 and both flags cleared.
